// File: rtl/loop_addr_gen.sv
// loop_addr_gen: per-iteration address generator fed by the loop controller.
// Each accepted innermost step emits the current address one cycle later and
// advances it by that loop's signed stride. A loop's last iteration rewinds the
// address by everything that loop has accumulated.
// Optional feature macro: LOOP_ADDR_GEN_BOUNDS_CHECK_EN adds i_addr_limit and a
// sticky o_addr_oob flag raised by any emitted address >= i_addr_limit.
module loop_addr_gen #(
    parameter int LOOP_ID_W = 5,
    parameter int ADDR_W    = 32,
    parameter int STRIDE_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_cfg_stride_v,
    input  logic [STRIDE_W-1:0]  i_cfg_stride,
    input  logic [LOOP_ID_W-1:0] i_cfg_stride_loop_id,
    input  logic [ADDR_W-1:0]    i_base_addr,
    input  logic [LOOP_ID_W-1:0] i_loop_index,
    input  logic                 i_loop_index_valid,
    input  logic                 i_loop_last_iter,
    input  logic                 i_loop_init,
    input  logic                 i_loop_enter,
    input  logic                 i_loop_exit,
    input  logic                 i_stall,
    input  logic                 i_done,
`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
    input  logic [ADDR_W-1:0]    i_addr_limit,
    output logic                 o_addr_oob,
`endif
    output logic                 o_addr_v,
    output logic [ADDR_W-1:0]    o_addr,
    output logic                 o_busy,
    output logic                 o_cfg_err
);

    localparam int N_LOOPS = 1 << LOOP_ID_W;

    logic [STRIDE_W-1:0] r_stride [N_LOOPS];
    logic [ADDR_W-1:0]   r_acc    [N_LOOPS];
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_addr_v;
    logic                r_busy;
    logic                r_cfg_err;

    logic                w_step;
    logic                w_emit;
    logic                w_adv;
    logic                w_cfg_wr;
    logic [ADDR_W-1:0]   w_stride_ext;
    logic [ADDR_W-1:0]   w_acc_sel;

    // loop_enter carries no address work: the entered loop's accumulator is
    // already zero (cleared by init or by its previous last-iteration rewind).
    logic                w_unused_enter;
    assign w_unused_enter = i_loop_enter;

    // Event decode, priority: init > inner step > exit > enter.
    always_comb begin
        w_step       = i_loop_index_valid & ~i_stall;
        w_emit       = w_step & ~i_loop_init;
        w_adv        = ~i_loop_init & (w_step | i_loop_exit);
        w_cfg_wr     = i_cfg_stride_v & ~r_busy;
        w_stride_ext = ADDR_W'($signed(r_stride[i_loop_index]));
        w_acc_sel    = r_acc[i_loop_index];
    end

    // Stride table: writable only between runs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_LOOPS; i++) r_stride[i] <= '0;
        end else if (w_cfg_wr) begin
            r_stride[i_cfg_stride_loop_id] <= i_cfg_stride;
        end
    end

    // Per-loop accumulated offsets: cleared on init, advanced or rewound on steps/exits.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < N_LOOPS; i++) r_acc[i] <= '0;
        end else if (i_loop_init) begin
            for (int i = 0; i < N_LOOPS; i++) r_acc[i] <= '0;
        end else if (w_adv) begin
            if (i_loop_last_iter) r_acc[i_loop_index] <= '0;
            else                  r_acc[i_loop_index] <= w_acc_sel + w_stride_ext;
        end
    end

    // Running address: loaded with base on init, moved by stride or rewound.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cur_addr <= '0;
        end else if (i_loop_init) begin
            r_cur_addr <= i_base_addr;
        end else if (w_adv) begin
            if (i_loop_last_iter) r_cur_addr <= r_cur_addr - w_acc_sel;
            else                  r_cur_addr <= r_cur_addr + w_stride_ext;
        end
    end

    // Output address register: pre-update address, one cycle after the step.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_addr_v <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_addr_v <= w_emit;
            if (w_emit) r_addr <= r_cur_addr;
        end
    end

    // Run status and dropped-config error pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            if (i_loop_init) r_busy <= 1'b1;
            else if (i_done) r_busy <= 1'b0;
            r_cfg_err <= i_cfg_stride_v & r_busy;
        end
    end

`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
    logic r_oob;
    logic w_oob_hit;

    // Out-of-bounds hit on the address currently being presented.
    always_comb begin
        w_oob_hit = r_addr_v & (r_addr >= i_addr_limit);
    end

    // Sticky flag; the combinational OR makes it rise with the offending addr_v.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)       r_oob <= 1'b0;
        else if (i_loop_init) r_oob <= 1'b0;
        else if (w_oob_hit)   r_oob <= 1'b1;
    end

    assign o_addr_oob = r_oob | w_oob_hit;
`endif

    assign o_addr_v  = r_addr_v;
    assign o_addr    = r_addr;
    assign o_busy    = r_busy;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_loop_addr_gen.sv
// tb_loop_addr_gen: drives loop-controller event sequences for nested runs and
// compares every emitted address with base + sum(iter_i * stride_i) mod 2^32.
// Build with LOOP_ADDR_GEN_BOUNDS_CHECK_EN defined to include the bounds flag.
module tb_loop_addr_gen;

    localparam int LOOP_ID_W = 5;
    localparam int ADDR_W    = 32;
    localparam int STRIDE_W  = 16;

    logic                 i_clk = 1'b0;
    logic                 i_reset_n;
    logic                 i_cfg_stride_v;
    logic [STRIDE_W-1:0]  i_cfg_stride;
    logic [LOOP_ID_W-1:0] i_cfg_stride_loop_id;
    logic [ADDR_W-1:0]    i_base_addr;
    logic [LOOP_ID_W-1:0] i_loop_index;
    logic                 i_loop_index_valid;
    logic                 i_loop_last_iter;
    logic                 i_loop_init;
    logic                 i_loop_enter;
    logic                 i_loop_exit;
    logic                 i_stall;
    logic                 i_done;
    logic                 o_addr_v;
    logic [ADDR_W-1:0]    o_addr;
    logic                 o_busy;
    logic                 o_cfg_err;
`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
    logic [ADDR_W-1:0]    i_addr_limit;
    logic                 o_addr_oob;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0]   exp_q[$];
    logic [STRIDE_W-1:0] mdl_stride [1 << LOOP_ID_W];
    logic [ADDR_W-1:0]   last_exp;
    logic [ADDR_W-1:0]   mon_e;
    logic                mdl_oob;

    loop_addr_gen #(
        .LOOP_ID_W(LOOP_ID_W), .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W)
    ) dut (
        .i_clk                (i_clk),
        .i_reset_n            (i_reset_n),
        .i_cfg_stride_v       (i_cfg_stride_v),
        .i_cfg_stride         (i_cfg_stride),
        .i_cfg_stride_loop_id (i_cfg_stride_loop_id),
        .i_base_addr          (i_base_addr),
        .i_loop_index         (i_loop_index),
        .i_loop_index_valid   (i_loop_index_valid),
        .i_loop_last_iter     (i_loop_last_iter),
        .i_loop_init          (i_loop_init),
        .i_loop_enter         (i_loop_enter),
        .i_loop_exit          (i_loop_exit),
        .i_stall              (i_stall),
        .i_done               (i_done),
`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
        .i_addr_limit         (i_addr_limit),
        .o_addr_oob           (o_addr_oob),
`endif
        .o_addr_v             (o_addr_v),
        .o_addr               (o_addr),
        .o_busy               (o_busy),
        .o_cfg_err            (o_cfg_err)
    );

    // Clock.
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every addr_v pops the oldest expected address.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            mdl_oob = 1'b0;
        end else begin
            if (o_addr_v) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_addr_v", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("addr", 64'(o_addr), 64'(mon_e));
                    last_exp = mon_e;
`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
                    if (mon_e >= i_addr_limit) mdl_oob = 1'b1;
                    check_eq("addr_oob", 64'(o_addr_oob), 64'(mdl_oob));
`endif
                end
            end
            if (i_loop_init) mdl_oob = 1'b0;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr;
        i_cfg_stride_v     = 1'b0;
        i_loop_index_valid = 1'b0;
        i_loop_last_iter   = 1'b0;
        i_loop_init        = 1'b0;
        i_loop_enter       = 1'b0;
        i_loop_exit        = 1'b0;
        i_stall            = 1'b0;
        i_done             = 1'b0;
    endtask

    task automatic cfg(input int id, input logic [STRIDE_W-1:0] s, input logic exp_err);
        i_cfg_stride_loop_id = LOOP_ID_W'(id);
        i_cfg_stride         = s;
        i_cfg_stride_v       = 1'b1;
        tick();
        clr();
        check_eq("cfg_err", 64'(o_cfg_err), 64'(exp_err));
        if (!exp_err) mdl_stride[id] = s;
        tick();
        check_eq("cfg_err_clear", 64'(o_cfg_err), 64'd0);
    endtask

    task automatic do_init(input logic [ADDR_W-1:0] base);
        i_base_addr = base;
        i_loop_init = 1'b1;
        tick();
        clr();
        check_eq("busy_after_init", 64'(o_busy), 64'd1);
    endtask

    task automatic do_enter(input int id);
        i_loop_index = LOOP_ID_W'(id);
        i_loop_enter = 1'b1;
        tick();
        clr();
    endtask

    task automatic do_inner(input int id, input logic last, input int max_stall, input logic done);
        int ns;
        ns = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
        for (int k = 0; k < ns; k++) begin
            i_loop_index       = LOOP_ID_W'(id);
            i_loop_index_valid = 1'b1;
            i_stall            = 1'b1;
            i_loop_last_iter   = last;
            tick();
            check_eq("stall_no_addr_v", 64'(o_addr_v), 64'd0);
        end
        i_loop_index       = LOOP_ID_W'(id);
        i_loop_index_valid = 1'b1;
        i_stall            = 1'b0;
        i_loop_last_iter   = last;
        i_done             = done;
        tick();
        clr();
    endtask

    task automatic do_exit(input int id, input logic last);
        i_loop_index     = LOOP_ID_W'(id);
        i_loop_exit      = 1'b1;
        i_loop_last_iter = last;
        tick();
        clr();
    endtask

    task automatic do_done;
        check_eq("busy_before_done", 64'(o_busy), 64'd1);
        i_done = 1'b1;
        tick();
        clr();
        check_eq("busy_after_done", 64'(o_busy), 64'd0);
    endtask

    function automatic logic [ADDR_W-1:0] sext(input logic [STRIDE_W-1:0] s);
        return {{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s};
    endfunction

    // Two-level nest: outer loop oid runs 0..m1, inner loop iid runs 0..m0.
    task automatic run_2d(input logic [ADDR_W-1:0] base, input int oid, input int iid,
                          input int m1, input int m0, input int ms);
        for (int a = 0; a <= m1; a++)
            for (int b = 0; b <= m0; b++)
                exp_q.push_back(base + ADDR_W'(a) * sext(mdl_stride[oid])
                                     + ADDR_W'(b) * sext(mdl_stride[iid]));
        do_init(base);
        do_enter(oid);
        for (int a = 0; a <= m1; a++) begin
            do_enter(iid);
            for (int b = 0; b <= m0; b++) do_inner(iid, b == m0, ms, 1'b0);
            do_exit(oid, a == m1);
        end
        do_done();
        check_eq("drained_2d", 64'(exp_q.size()), 64'd0);
        check_eq("addr_hold", 64'(o_addr), 64'(last_exp));
    endtask

    // Single loop; optionally the done pulse rides on the last inner step.
    task automatic run_1d(input logic [ADDR_W-1:0] base, input int id, input int m0,
                          input int ms, input logic done_on_last);
        for (int b = 0; b <= m0; b++)
            exp_q.push_back(base + ADDR_W'(b) * sext(mdl_stride[id]));
        do_init(base);
        do_enter(id);
        for (int b = 0; b < m0; b++) do_inner(id, 1'b0, ms, 1'b0);
        if (done_on_last) begin
            do_inner(id, 1'b1, ms, 1'b1);
            check_eq("busy_after_done_step", 64'(o_busy), 64'd0);
            check_eq("addr_v_with_done", 64'(o_addr_v), 64'd1);
            tick();
        end else begin
            do_inner(id, 1'b1, ms, 1'b0);
            do_done();
        end
        check_eq("drained_1d", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        clr();
        i_reset_n            = 1'b0;
        i_cfg_stride         = '0;
        i_cfg_stride_loop_id = '0;
        i_base_addr          = '0;
        i_loop_index         = '0;
        last_exp             = '0;
        mdl_oob              = 1'b0;
`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
        i_addr_limit         = '1;
`endif
        for (int i = 0; i < (1 << LOOP_ID_W); i++) mdl_stride[i] = '0;

        // Reset state.
        #12;
        check_eq("rst_addr_v", 64'(o_addr_v), 64'd0);
        check_eq("rst_addr", 64'(o_addr), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_cfg_err", 64'(o_cfg_err), 64'd0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // 2x3 nest, strides 1 and 16.
        cfg(0, 16'd1, 1'b0);
        cfg(1, 16'd16, 1'b0);
        run_2d(32'h100, 1, 0, 1, 2, 0);

        // Stall held three cycles between inner steps.
        cfg(0, 16'd4, 1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        do_init(32'h0);
        do_enter(0);
        for (int b = 0; b <= 2; b++) begin
            if (b == 1) begin
                for (int k = 0; k < 3; k++) begin
                    i_loop_index_valid = 1'b1;
                    i_stall            = 1'b1;
                    i_loop_index       = '0;
                    tick();
                    check_eq("stall_hold", 64'(o_addr_v), 64'd0);
                end
            end
            do_inner(0, b == 2, 0, 1'b0);
        end
        do_done();
        check_eq("drained_stall", 64'(exp_q.size()), 64'd0);

        // Negative stride with wrap below zero.
        cfg(0, 16'hFFFE, 1'b0);
        run_1d(32'h2, 0, 2, 1, 1'b0);

        // Zero stride repeats the address.
        cfg(0, 16'h0, 1'b0);
        run_1d(32'h55, 0, 2, 0, 1'b1);

        // Config dropped while busy, accepted afterwards.
        cfg(0, 16'd3, 1'b0);
        for (int b = 0; b <= 2; b++) exp_q.push_back(32'h10 + ADDR_W'(b) * 32'd3);
        do_init(32'h10);
        cfg(0, 16'd7, 1'b1);
        do_enter(0);
        for (int b = 0; b <= 2; b++) do_inner(0, b == 2, 0, 1'b0);
        do_done();
        check_eq("drained_cfg_busy", 64'(exp_q.size()), 64'd0);
        cfg(0, 16'd7, 1'b0);
        run_1d(32'h0, 0, 2, 0, 1'b0);

        // Asynchronous reset after two addresses.
        cfg(0, 16'd1, 1'b0);
        exp_q.push_back(32'h200); exp_q.push_back(32'h201);
        do_init(32'h200);
        do_enter(0);
        do_inner(0, 1'b0, 0, 1'b0);
        do_inner(0, 1'b0, 0, 1'b0);
        @(negedge i_clk);
        #1;
        check_eq("pre_reset_addr", 64'(o_addr), 64'h201);
        i_reset_n = 1'b0;
        #1;
        check_eq("mid_rst_addr_v", 64'(o_addr_v), 64'd0);
        check_eq("mid_rst_addr", 64'(o_addr), 64'd0);
        check_eq("mid_rst_busy", 64'(o_busy), 64'd0);
        check_eq("drained_reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        for (int i = 0; i < (1 << LOOP_ID_W); i++) mdl_stride[i] = '0;
        tick();
        i_reset_n = 1'b1;
        tick();
        run_1d(32'h40, 0, 1, 0, 1'b0);

`ifdef LOOP_ADDR_GEN_BOUNDS_CHECK_EN
        // Bounds flag: rises with 0x110, sticky until next init.
        i_addr_limit = 32'h103;
        cfg(0, 16'd1, 1'b0);
        cfg(1, 16'd16, 1'b0);
        run_2d(32'h100, 1, 0, 1, 2, 0);
        check_eq("oob_sticky", 64'(o_addr_oob), 64'd1);
        do_init(32'h0);
        check_eq("oob_cleared", 64'(o_addr_oob), 64'd0);
        do_done();
        i_addr_limit = '1;
`endif

        // Randomized nests.
        for (int r = 0; r < 24; r++) begin
            int oid;
            int iid;
            oid = $urandom_range(0, (1 << LOOP_ID_W) - 1);
            iid = (oid + $urandom_range(1, (1 << LOOP_ID_W) - 1)) % (1 << LOOP_ID_W);
            cfg(oid, STRIDE_W'($urandom), 1'b0);
            cfg(iid, STRIDE_W'($urandom), 1'b0);
            if (r % 3 == 0)
                run_1d(ADDR_W'($urandom), iid, $urandom_range(0, 5), 2, 1'($urandom_range(0, 1)));
            else
                run_2d(ADDR_W'($urandom), oid, iid, $urandom_range(0, 3), $urandom_range(0, 4), 2);
        end

        repeat (3) tick();
        check_eq("final_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
